// File: rtl/food_gen_if.sv
// Occupancy query bus between the food placer and the body-occupancy store.
// qReq is a one-cycle strobe with qX/qY valid alongside it; qOcc is the answer for that cell, presented in the following cycle.
interface food_gen_if;
    logic       qReq;
    logic [3:0] qX;
    logic [3:0] qY;
    logic       qOcc;

    modport master (output qReq, output qX, output qY, input qOcc);
    modport slave  (input qReq, input qX, input qY, output qOcc);
endinterface

// File: rtl/food_gen.sv
// Places food on a free cell of a 16x8 board: random LFSR candidates first, then a linear scan,
// and reports when the head eats the food or the board has no free cell.
module food_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  headX,
    input  logic [3:0]  headY,
    input  logic        headValid,
    food_gen_if.master  q,
    output logic [3:0]  foodX,
    output logic [3:0]  foodY,
    output logic        foodValid,
    output logic        eaten,
    output logic        boardFull,
    output logic [2:0]  dbgState
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        PLACED = 3'd3,
        FULL   = 3'd4
    } state_t;

    localparam logic [8:0] MAX_T9 = 9'(MAX_TRIES);

    state_t      state;
    state_t      nextState;
    logic [15:0] lfsr;
    logic [15:0] lfsrNext;
    logic [3:0]  candX;
    logic [2:0]  candY;
    logic [7:0]  tries;
    logic        scanMode;
    logic [6:0]  scanCnt;
    logic        reachMax;

    logic loadRand;
    logic stepCand;
    logic place;
    logic goFull;
    logic eatNow;
    logic clearSearch;

    assign lfsrNext = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};
    assign reachMax = ({1'b0, tries} + 9'd1) >= MAX_T9;

    assign q.qReq   = (state == REQ);
    assign q.qX     = candX;
    assign q.qY     = {1'b0, candY};
    assign dbgState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // start overrides everything, including an eat in the same cycle
    always_comb begin
        nextState   = state;
        loadRand    = 1'b0;
        stepCand    = 1'b0;
        place       = 1'b0;
        goFull      = 1'b0;
        eatNow      = 1'b0;
        clearSearch = 1'b0;
        if (start) begin
            nextState   = REQ;
            loadRand    = 1'b1;
            clearSearch = 1'b1;
        end else begin
            case (state)
                IDLE: nextState = IDLE;
                REQ:  nextState = WAIT;
                WAIT: begin
                    if (!q.qOcc) begin
                        nextState = PLACED;
                        place     = 1'b1;
                    end else if (scanMode && scanCnt == 7'd127) begin
                        nextState = FULL;
                        goFull    = 1'b1;
                    end else begin
                        nextState = REQ;
                        stepCand  = 1'b1;
                    end
                end
                PLACED: begin
                    if (headValid && headX == foodX && headY == foodY) begin
                        nextState   = REQ;
                        eatNow      = 1'b1;
                        loadRand    = 1'b1;
                        clearSearch = 1'b1;
                    end
                end
                FULL:    nextState = FULL;
                default: nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= LFSR_SEED;
            candX     <= 4'd0;
            candY     <= 3'd0;
            tries     <= 8'd0;
            scanMode  <= 1'b0;
            scanCnt   <= 7'd0;
            foodX     <= 4'd0;
            foodY     <= 4'd0;
            foodValid <= 1'b0;
            eaten     <= 1'b0;
            boardFull <= 1'b0;
        end else begin
            lfsr  <= lfsrNext;
            eaten <= eatNow;

            if (clearSearch) begin
                tries     <= 8'd0;
                scanMode  <= 1'b0;
                scanCnt   <= 7'd0;
                foodValid <= 1'b0;
                boardFull <= 1'b0;
            end

            if (place) begin
                foodX     <= candX;
                foodY     <= {1'b0, candY};
                foodValid <= 1'b1;
            end

            if (goFull) begin
                boardFull <= 1'b1;
                foodValid <= 1'b0;
            end

            if (stepCand) begin
                if (scanMode) begin
                    scanCnt <= scanCnt + 7'd1;
                end else begin
                    tries <= tries + 8'd1;
                    if (reachMax) scanMode <= 1'b1;
                end
            end

            // Y:X as one 7-bit index makes "+1" wrap X into the next row and row 7 back to 0
            if (loadRand || (stepCand && !scanMode && !reachMax)) begin
                candX <= lfsr[3:0];
                candY <= lfsr[6:4];
            end else if (stepCand) begin
                {candY, candX} <= {candY, candX} + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_food_gen.sv
// Bench for food_gen: two instances (MAX_TRIES 8 and 1) against a board-level placement model.
module tb_food_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start [2];
  logic        headValid [2];
  logic [3:0]  headX [2];
  logic [3:0]  headY [2];
  logic [3:0]  foodX [2];
  logic [3:0]  foodY [2];
  logic        foodValid [2];
  logic        eaten [2];
  logic        boardFull [2];
  logic [2:0]  dbgState [2];
  logic [127:0] occMap [2];

  food_gen_if bus8();
  food_gen_if bus1();

  assign bus8.qOcc = occMap[0][{bus8.qY[2:0], bus8.qX}];
  assign bus1.qOcc = occMap[1][{bus1.qY[2:0], bus1.qX}];

  logic       qReqS [2];
  logic [3:0] qXS [2];
  logic [3:0] qYS [2];
  assign qReqS[0] = bus8.qReq;
  assign qReqS[1] = bus1.qReq;
  assign qXS[0]   = bus8.qX;
  assign qXS[1]   = bus1.qX;
  assign qYS[0]   = bus8.qY;
  assign qYS[1]   = bus1.qY;

  food_gen #(.LFSR_SEED(SEED), .MAX_TRIES(8)) dut8 (
    .clk(clk), .reset(reset), .start(start[0]), .headX(headX[0]), .headY(headY[0]),
    .headValid(headValid[0]), .q(bus8), .foodX(foodX[0]), .foodY(foodY[0]),
    .foodValid(foodValid[0]), .eaten(eaten[0]), .boardFull(boardFull[0]), .dbgState(dbgState[0])
  );

  food_gen #(.LFSR_SEED(SEED), .MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .headX(headX[1]), .headY(headY[1]),
    .headValid(headValid[1]), .q(bus1), .foodX(foodX[1]), .foodY(foodY[1]),
    .foodValid(foodValid[1]), .eaten(eaten[1]), .boardFull(boardFull[1]), .dbgState(dbgState[1])
  );

  int checks = 0;
  int errors = 0;

  // Query logs, entries are {qY, qX}
  logic [7:0] qlog0[$];
  logic [7:0] qlog1[$];
  // Expected query sequence, entries are the 7-bit cell index row*16+col
  logic [6:0] exp_q[$];

  always @(negedge clk) begin
    if (bus8.qReq) qlog0.push_back({bus8.qY, bus8.qX});
    if (bus1.qReq) qlog1.push_back({bus1.qY, bus1.qX});
  end

  function automatic logic [15:0] lfsrStep(logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Free-running reference copy of the random source
  logic [15:0] tbLfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) tbLfsr <= SEED;
    else        tbLfsr <= lfsrStep(tbLfsr);
  end

  function automatic int maxTriesOf(int d);
    return (d == 0) ? 8 : 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog(int d);
    if (d == 0) qlog0.delete();
    else        qlog1.delete();
  endtask

  function automatic int logSize(int d);
    return (d == 0) ? qlog0.size() : qlog1.size();
  endfunction

  // Random candidate k comes from the source two cycles per attempt after l0;
  // once attempts are spent, cells are visited in index order from the last candidate.
  task automatic modelSearch(int d, logic [15:0] l0, output bit expFull);
    logic [15:0] l;
    logic [6:0]  c;
    bit          placed;
    exp_q.delete();
    l = l0;
    placed = 0;
    c = '0;
    for (int k = 0; k < maxTriesOf(d) && !placed; k++) begin
      c = {l[6:4], l[3:0]};
      exp_q.push_back(c);
      if (!occMap[d][c]) placed = 1;
      l = lfsrStep(lfsrStep(l));
    end
    for (int s = 0; s < 128 && !placed; s++) begin
      c = c + 7'd1;
      exp_q.push_back(c);
      if (!occMap[d][c]) placed = 1;
    end
    expFull = !placed;
  endtask

  task automatic pulseStart(int d, output logic [15:0] l0);
    clearLog(d);
    l0 = tbLfsr;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  task automatic checkSearch(int d, logic [15:0] l0, string name);
    bit expFull;
    int n;
    int mism;
    logic [7:0] got[$];
    modelSearch(d, l0, expFull);
    n = 0;
    while (!(foodValid[d] || boardFull[d]) && n < 400) begin
      step();
      n++;
    end
    check({name, " settled"}, {31'd0, foodValid[d] | boardFull[d]}, 1);
    got = (d == 0) ? qlog0 : qlog1;
    check({name, " query count"}, got.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== {1'b0, exp_q[i]}) mism++;
    check({name, " query cells"}, mism, 0);
    check({name, " boardFull"}, boardFull[d], expFull);
    check({name, " foodValid"}, foodValid[d], !expFull);
    if (!expFull)
      check({name, " food cell"}, {foodY[d], foodX[d]}, {1'b0, exp_q[exp_q.size()-1]});
  endtask

  task automatic checkResetOutputs(int d, string name);
    check({name, " qReq"}, qReqS[d], 0);
    check({name, " qX/qY"}, {qYS[d], qXS[d]}, 0);
    check({name, " food"}, {foodY[d], foodX[d]}, 0);
    check({name, " flags"}, {foodValid[d], eaten[d], boardFull[d]}, 0);
  endtask

  typedef struct {
    logic       hv;
    logic [3:0] hx;
    logic [3:0] hy;
    logic       expEat;
  } eat_vec_t;

  eat_vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] l0;
    int n;

    vecs[0] = '{hv: 1'b1, hx: 4'd5,  hy: 4'd2,  expEat: 1'b0};
    vecs[1] = '{hv: 1'b1, hx: 4'd4,  hy: 4'd3,  expEat: 1'b0};
    vecs[2] = '{hv: 1'b0, hx: 4'd5,  hy: 4'd3,  expEat: 1'b0};
    vecs[3] = '{hv: 1'b1, hx: 4'd5,  hy: 4'd11, expEat: 1'b0};
    vecs[4] = '{hv: 1'b1, hx: 4'd15, hy: 4'd7,  expEat: 1'b0};
    vecs[5] = '{hv: 1'b1, hx: 4'd5,  hy: 4'd3,  expEat: 1'b1};

    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      headValid[d] = 1'b0;
      headX[d] = 4'd0;
      headY[d] = 4'd0;
      occMap[d] = '0;
    end

    // Reset values, then idle until start
    #2;
    checkResetOutputs(0, "reset dut8");
    checkResetOutputs(1, "reset dut1");
    repeat (3) step();
    reset = 1'b1;
    n = 0;
    repeat (6) begin
      step();
      if (qReqS[0] || qReqS[1] || foodValid[0] || foodValid[1]) n++;
    end
    check("idle after reset", n, 0);

    // Empty board: exact start latency
    for (int r = 0; r < 4; r++) begin
      bit ef;
      repeat ($urandom_range(0, 5)) step();
      pulseStart(0, l0);
      modelSearch(0, l0, ef);
      check("empty T+1 qReq", qReqS[0], 1);
      check("empty T+1 foodValid", foodValid[0], 0);
      step();
      check("empty T+2 qReq", qReqS[0], 0);
      check("empty T+2 foodValid", foodValid[0], 0);
      step();
      check("empty T+3 foodValid", foodValid[0], 1);
      check("empty foodY range", {31'd0, foodY[0] < 4'd8}, 1);
      check("empty food cell", {foodY[0], foodX[0]}, {1'b0, exp_q[0]});
      check("empty eaten", eaten[0], 0);
      check("empty query count", logSize(0), 1);
    end

    // Random boards of varying density on both instances
    for (int r = 0; r < 8; r++) begin
      int d;
      int dens;
      d = r % 2;
      dens = (r < 2) ? 50 : (r < 4) ? 90 : 98;
      if (r >= 6) begin
        occMap[d] = '1;
        occMap[d][$urandom_range(0, 127)] = 1'b0;
      end else begin
        for (int i = 0; i < 128; i++) occMap[d][i] = ($urandom_range(0, 99) < dens);
      end
      pulseStart(d, l0);
      checkSearch(d, l0, "random board");
    end

    // One random try then scan wrapping through (15,7) to the only free cell (0,0)
    occMap[1] = '1;
    occMap[1][0] = 1'b0;
    pulseStart(1, l0);
    checkSearch(1, l0, "scan wrap");

    // Full board: 8 random + 128 scan queries, FULL is sticky until start
    occMap[0] = '1;
    pulseStart(0, l0);
    checkSearch(0, l0, "full board");
    check("full query total", logSize(0), 136);
    repeat (10) step();
    check("full holds queries", logSize(0), 136);
    check("full holds boardFull", boardFull[0], 1);
    pulseStart(0, l0);
    check("restart boardFull", boardFull[0], 0);
    check("restart qReq", qReqS[0], 1);

    // Asynchronous reset while waiting for an answer
    step();
    check("in wait qReq", qReqS[0], 0);
    #1 reset = 1'b0;
    #1;
    checkResetOutputs(0, "async reset");
    step();
    reset = 1'b1;
    n = logSize(0);
    repeat (20) step();
    check("no qReq after reset", logSize(0), n);

    // Eat table: only (5,3) is free so the food is known
    occMap[0] = '1;
    occMap[0][{3'd3, 4'd5}] = 1'b0;
    pulseStart(0, l0);
    checkSearch(0, l0, "place 5,3");
    for (int i = 0; i < 6; i++) begin
      clearLog(0);
      l0 = tbLfsr;
      headX[0] = vecs[i].hx;
      headY[0] = vecs[i].hy;
      headValid[0] = vecs[i].hv;
      step();
      headValid[0] = 1'b0;
      check($sformatf("eat vec%0d eaten", i), eaten[0], vecs[i].expEat);
      check($sformatf("eat vec%0d foodValid", i), foodValid[0], !vecs[i].expEat);
      check($sformatf("eat vec%0d qReq", i), qReqS[0], vecs[i].expEat);
    end
    step();
    check("eaten single pulse", eaten[0], 0);
    checkSearch(0, l0, "after eat");

    // start and eat together: start wins
    clearLog(0);
    l0 = tbLfsr;
    headX[0] = 4'd5;
    headY[0] = 4'd3;
    headValid[0] = 1'b1;
    start[0] = 1'b1;
    step();
    headValid[0] = 1'b0;
    start[0] = 1'b0;
    check("start prio eaten", eaten[0], 0);
    check("start prio qReq", qReqS[0], 1);
    check("start prio foodValid", foodValid[0], 0);
    checkSearch(0, l0, "start prio");
    step();
    check("start prio no late eaten", eaten[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
